// File: rtl/sqrt_square_chk_if.sv
// sqrt_square_chk_if: operand/result bundle for sqrt_square_chk.
//   master: drives vld_in, y, x; observes rdy, vld_out, sq, ok.
//   slave : the squarer/checker side.
//   W     : root width; radicand and square are 2W bits.
interface sqrt_square_chk_if #(
  parameter int unsigned W = 16
);
  logic             vld_in;
  logic             rdy;
  logic [W-1:0]     y;
  logic [2*W-1:0]   x;
  logic             vld_out;
  logic [2*W-1:0]   sq;
  logic             ok;

  modport master (
    output vld_in, y, x,
    input  rdy, vld_out, sq, ok
  );

  modport slave (
    input  vld_in, y, x,
    output rdy, vld_out, sq, ok
  );
endinterface

// File: rtl/sqrt_square_chk.sv
// sqrt_square_chk: iterative squarer and floor-square-root checker.
//   Accepts root y (and radicand x), computes y*y with a W-step shift-add,
//   and reports it on sq with a one-cycle vld_out strobe. With checking
//   built in, ok flags whether y == floor(sqrt(x)).
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus.vld_in operand valid;  bus.rdy   ready for an operand
//   bus.y      root (W bits);  bus.x     radicand (2W bits)
//   bus.vld_out result strobe; bus.sq    y*y (2W bits); bus.ok check flag
// Configuration macro: SQRT_CHECK_EN
//   defined   -> x registered, ok = (sq <= x < (y+1)^2)
//   undefined -> x ignored, ok tied 0; timing and ports unchanged
module sqrt_square_chk #(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                rst,
  sqrt_square_chk_if.slave    bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [W-1:0]     y_reg;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   acc_nxt;
  logic [2*W-1:0]   y_ext;
  logic [CW-1:0]    cnt;
  logic             rdy_r;
  logic             vld_r;
  logic [2*W-1:0]   sq_r;
  logic             ok_r;
  logic             ok_nxt;

  assign y_ext = {{W{1'b0}}, y_reg};

  // Partial product for the current bit; the final sum feeds sq directly.
  always_comb begin
    acc_nxt = acc;
    if (y_reg[cnt]) begin
      acc_nxt = acc + (y_ext << cnt);
    end
  end

`ifdef SQRT_CHECK_EN
  logic [2*W-1:0]   x_reg;
  logic [2*W:0]     diff;
  logic [W:0]       two_y;

  // Extra top bit of diff is the borrow, i.e. x < sq.
  assign diff   = {1'b0, x_reg} - {1'b0, acc_nxt};
  assign two_y  = {y_reg, 1'b0};
  assign ok_nxt = ~diff[2*W] && (diff[2*W-1:0] <= {{(W-1){1'b0}}, two_y});
`else
  logic unused_x;
  assign unused_x = ^bus.x;
  assign ok_nxt   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rdy_r <= 1'b1;
      vld_r <= 1'b0;
      sq_r  <= '0;
      ok_r  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      y_reg <= '0;
`ifdef SQRT_CHECK_EN
      x_reg <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          vld_r <= 1'b0;
          if (bus.vld_in) begin
            y_reg <= bus.y;
`ifdef SQRT_CHECK_EN
            x_reg <= bus.x;
`endif
            acc   <= '0;
            cnt   <= '0;
            rdy_r <= 1'b0;
            state <= BUSY;
          end else begin
            rdy_r <= 1'b1;
            state <= IDLE;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            sq_r  <= acc_nxt;
            ok_r  <= ok_nxt;
            vld_r <= 1'b1;
            rdy_r <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          rdy_r <= 1'b1;
          vld_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy     = rdy_r;
  assign bus.vld_out = vld_r;
  assign bus.sq      = sq_r;
  assign bus.ok      = ok_r;

endmodule
